// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: FUN3 codes, FSM states and size decode.
package mem_access_unit_pkg;

  // Load/store width codes carried in FUN3.
  localparam logic [2:0] Fun3Byte   = 3'b000;
  localparam logic [2:0] Fun3Half   = 3'b001;
  localparam logic [2:0] Fun3Word   = 3'b010;
  localparam logic [2:0] Fun3Double = 3'b011;
  localparam logic [2:0] Fun3ByteU  = 3'b100;
  localparam logic [2:0] Fun3HalfU  = 3'b101;
  localparam logic [2:0] Fun3WordU  = 3'b110;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StResp
  } mau_state_e;

  // log2 of the access size in bytes.
  function automatic logic [1:0] fun3_size_log2(input logic [2:0] fun3);
    logic [1:0] size;
    case (fun3)
      Fun3Byte, Fun3ByteU: size = 2'd0;
      Fun3Half, Fun3HalfU: size = 2'd1;
      Fun3Word, Fun3WordU: size = 2'd2;
      default:             size = 2'd3;
    endcase
    return size;
  endfunction

  // Unsigned loads have no store counterpart; 64-bit forms need a 64-bit datapath.
  function automatic logic fun3_legal(input logic [2:0] fun3, input logic is_store,
                                      input logic is_rv64);
    logic legal;
    case (fun3)
      Fun3Byte, Fun3Half, Fun3Word: legal = 1'b1;
      Fun3Double:                   legal = is_rv64;
      Fun3ByteU, Fun3HalfU:         legal = !is_store;
      Fun3WordU:                    legal = !is_store && is_rv64;
      default:                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering: store rotate and byte enables, load merge and sign/zero extension.
module mau_lane_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] i_offset,
  input  logic [1:0]                i_size,
  input  logic                      i_unsigned,
  input  logic [XLEN-1:0]           i_wdata,
  input  logic [XLEN-1:0]           i_rdata0,
  input  logic [XLEN-1:0]           i_rdata1,
  output logic [XLEN/8-1:0]         o_be0,
  output logic [XLEN/8-1:0]         o_be1,
  output logic [XLEN-1:0]           o_wdata,
  output logic [XLEN-1:0]           o_rdata
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  logic [2*NB-1:0] w_size_mask;
  logic [2*NB-1:0] w_be_shifted;
  logic [OW+2:0]   w_bit_off;
  logic [OW+3:0]   w_rot_amt;
  logic [7:0]      w_ext_bits;
  logic [XLEN-1:0] w_merged;
  logic [XLEN-1:0] w_keep_mask;
  logic            w_sign;

  assign w_bit_off = {i_offset, 3'b000};

  // Byte mask of the access, spilling into the upper half when it crosses a word.
  assign w_size_mask  = (2*NB)'((16'd1 << (4'd1 << i_size)) - 16'd1);
  assign w_be_shifted = w_size_mask << i_offset;
  assign o_be0        = w_be_shifted[NB-1:0];
  assign o_be1        = w_be_shifted[2*NB-1:NB];

  // Rotate left by the byte offset so each beat finds its bytes in the right lanes.
  assign w_rot_amt = (OW+4)'(XLEN) - (OW+4)'(w_bit_off);
  assign o_wdata   = XLEN'({i_wdata, i_wdata} >> w_rot_amt);

  // Beat-0 upper bytes followed by beat-1 lower bytes.
  assign w_merged    = XLEN'({i_rdata1, i_rdata0} >> w_bit_off);
  assign w_ext_bits  = 8'd8 << i_size;
  assign w_keep_mask = ~({XLEN{1'b1}} << w_ext_bits);
  assign w_sign      = !i_unsigned && |(w_merged & (XLEN'(1) << (w_ext_bits - 8'd1)));
  assign o_rdata     = w_sign ? (w_merged | ~w_keep_mask) : (w_merged & w_keep_mask);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one CPU request becomes one or two aligned bus beats.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);

  mau_state_e      r_state, w_next_state;
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata0;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_fault;

  logic            w_accept;
  logic [2:0]      w_req_low_mask;
  logic            w_req_misaligned;
  logic            w_req_fault;
  logic [1:0]      w_size;
  logic            w_cross;
  logic [NB-1:0]   w_be0, w_be1;
  logic [XLEN-1:0] w_beat0_addr, w_beat1_addr;
  logic [XLEN-1:0] w_wdata_rot, w_load_data, w_lane_rdata0;

  assign w_accept = req_valid && req_ready;

  // Fault is decided at acceptance so faulting requests never touch the bus.
  assign w_req_low_mask   = (3'd1 << fun3_size_log2(req_funct3)) - 3'd1;
  assign w_req_misaligned = |(req_addr[2:0] & w_req_low_mask);
  assign w_req_fault      = !fun3_legal(req_funct3, req_we, XLEN == 64) ||
                            (!MISALIGN_EN && w_req_misaligned);

  assign w_size        = fun3_size_log2(r_funct3);
  assign w_beat0_addr  = {r_addr[XLEN-1:OW], {OW{1'b0}}};
  assign w_beat1_addr  = w_beat0_addr + XLEN'(NB);
  assign w_cross       = |w_be1;
  // In WAIT0 the live bus data is beat 0; by WAIT1 it has been captured.
  assign w_lane_rdata0 = (r_state == StWait0) ? mem_rdata : r_rdata0;

  mau_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .i_offset  (r_addr[OW-1:0]),
    .i_size    (w_size),
    .i_unsigned(r_funct3[2]),
    .i_wdata   (r_wdata),
    .i_rdata0  (w_lane_rdata0),
    .i_rdata1  (mem_rdata),
    .o_be0     (w_be0),
    .o_be1     (w_be1),
    .o_wdata   (w_wdata_rot),
    .o_rdata   (w_load_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_next_state = w_req_fault ? StResp : StReq0;
      StReq0:  if (mem_gnt) w_next_state = StWait0;
      StWait0: if (mem_rvalid) w_next_state = w_cross ? StReq1 : StResp;
      StReq1:  if (mem_gnt) w_next_state = StWait1;
      StWait1: if (mem_rvalid) w_next_state = StResp;
      StResp:  if (resp_ready) w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  // Outputs decoded from state; bus fields are zero whenever no beat is offered.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (r_state)
      StIdle: req_ready = 1'b1;
      StReq0: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_be    = w_be0;
        mem_addr  = w_beat0_addr;
        mem_wdata = w_wdata_rot;
      end
      StReq1: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_be    = w_be1;
        mem_addr  = w_beat1_addr;
        mem_wdata = w_wdata_rot;
      end
      StResp:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_rdata = r_resp_rdata;
  assign resp_fault = r_resp_fault;

  // Request capture and response assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_resp_rdata <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we         <= req_we;
        r_funct3     <= req_funct3;
        r_addr       <= req_addr;
        r_wdata      <= req_wdata;
        r_resp_fault <= w_req_fault;
        r_resp_rdata <= '0;
      end
      if ((r_state == StWait0) && mem_rvalid) begin
        r_rdata0 <= mem_rdata;
        if (!w_cross) r_resp_rdata <= r_we ? '0 : w_load_data;
      end
      if ((r_state == StWait1) && mem_rvalid) begin
        r_resp_rdata <= r_we ? '0 : w_load_data;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XLEN, 32, datapath width in bits (32 or 64).
- MISALIGN_EN, 1, 1 = split misaligned accesses into two bus beats; 0 = report fault.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  unit accepts request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  load/store FUN3.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, LSB-justified.
- resp_valid  out  1  result valid.
- resp_ready  in  1  CPU takes result.
- resp_rdata  out  XLEN  extended load data.
- resp_fault  out  1  access rejected.
- mem_req  out  1  bus request.
- mem_gnt  in  1  bus accepted request.
- mem_we  out  1  bus write.
- mem_be  out  XLEN/8  byte enables.
- mem_addr  out  XLEN  aligned bus address.
- mem_wdata  out  XLEN  lane-positioned store data.
- mem_rvalid  in  1  bus response (read data or write ack).
- mem_rdata  in  XLEN  bus read data.

Function
REQ-003 FUN3 SHALL decode as 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (loads, XLEN=64 only); stores accept only 000–011.
REQ-004 Any other FUN3 SHALL complete with resp_fault=1, no bus beat, resp_valid one cycle after acceptance.
REQ-005 Misaligned SHALL mean (addr mod size) != 0. If MISALIGN_EN=0, a misaligned access SHALL fault like REQ-004.
REQ-006 FSM states SHALL be IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; req_ready=1 only in IDLE.
REQ-007 Transitions:
- IDLE→REQ0 on handshake (request registered).
- REQ0→WAIT0 on mem_gnt.
- WAIT0→REQ1 on mem_rvalid if the access crosses a XLEN/8 boundary, else →RESP.
- REQ1→WAIT1 on mem_gnt.
- WAIT1→RESP on mem_rvalid.
- RESP→IDLE on resp_ready.
REQ-008 mem_req SHALL be 1 exactly in REQ0/REQ1, with mem_addr/mem_be/mem_wdata/mem_we stable until mem_gnt.
REQ-009 Beat 0 SHALL use addr with low log2(XLEN/8) bits cleared; beat 1 SHALL use beat-0 address + XLEN/8, wrapping modulo 2^XLEN.
REQ-010 Beat 0 mem_be SHALL be the size mask shifted left by the offset, truncated to XLEN/8 bits; beat 1 mem_be SHALL be the shifted-out bits. mem_wdata SHALL rotate store data by offset bytes.
REQ-011 Load data SHALL merge beat-0 upper bytes with beat-1 lower bytes, then sign- or zero-extend per FUN3; stores return resp_rdata=0.
REQ-012 Minimum latency, aligned access with gnt and rvalid immediate: acceptance at T, mem_req at T+1, rvalid at T+2, resp_valid at T+3.
REQ-013 resp_valid, resp_rdata and resp_fault SHALL hold until resp_ready; a new request SHALL NOT be accepted in the same cycle as resp_ready.
REQ-014 mem_rvalid outside WAIT0/WAIT1 SHALL be ignored.

Reset
REQ-015 rst_n low SHALL force IDLE immediately, including mid-transaction. All outputs SHALL reset to 0 except req_ready, which reads 1 in IDLE. Any pending bus response after reset SHALL be dropped per REQ-014.

Structure
REQ-016 The shared package SHALL hold the FUN3 codes (extending the existing BYTE/HALF/WORD definitions with DOUBLE/WORD_U), the FSM state enum, and the size-from-FUN3 function.
REQ-017 One sub-module, mau_lane_align, SHALL be combinational and perform the store rotate/byte-enable generation and load merge/extension.

Verification
REQ-018 Benches SHALL cover these directed scenarios:
- XLEN=32, LW at 0x100, rdata 0x8000_00FF -> one beat, be=1111, resp_rdata 0x8000_00FF at T+3.
- XLEN=32, LH at 0x103, beat0 rdata 0xAB00_0000, beat1 0x0000_00CD -> beats at 0x100 (be 1000) and 0x104 (be 0001), resp_rdata 0xFFFF_CDAB.
- XLEN=32, SW 0x1122_3344 at 0x102 -> beat0 be=1100, wdata 0x3344_xxxx; beat1 be=0011, wdata 0xxxxx_1122.
- XLEN=64, LWU at 0x4, rdata 0xFFFF_FFFF_0000_0000 -> resp_rdata 0x0000_0000_FFFF_FFFF.
- MISALIGN_EN=0, LW at 0x101 or FUN3=111 -> resp_fault=1, mem_req never asserted.
- rst_n low while in WAIT0, late rvalid -> IDLE, no resp_valid, next request accepted normally.
